// File: rtl/ascon_tag_verify.sv
// Constant-time compare of the computed ASCON tag against a received tag streamed MSW first.
// Latency: verdict 1 cycle after the last word; backpressure via rx_ready_o, high only in RECV.
module ascon_tag_verify #(
    parameter int TAG_W  = 128,
    parameter int WORD_W = 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic              tag_valid_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] rx_word_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tag_ok_o
);
    localparam int NW = TAG_W / WORD_W;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_TAG = 2'd1,
        RECV     = 2'd2,
        RESULT   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [WORD_W-1:0] r_diff;
    logic [WORD_W-1:0] w_diff_nxt;
    logic              r_tag_ok;
    logic              w_tag_ok_nxt;
    logic              w_hs;
    logic              w_last;
    logic [TAG_W-1:0]  w_tag_sh;
    logic [WORD_W-1:0] w_tag_word;

    // Word k of the computed tag, counted from the most-significant end
    assign w_tag_sh   = tag_i >> ((NW - 1 - int'(r_cnt)) * WORD_W);
    assign w_tag_word = w_tag_sh[WORD_W-1:0];
    assign w_hs       = (r_state == RECV) && rx_valid_i;
    assign w_last     = (r_cnt == CW'(NW - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_diff_nxt   = r_diff;
        w_tag_ok_nxt = r_tag_ok;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt  = WAIT_TAG;
                    w_cnt_nxt    = '0;
                    w_diff_nxt   = '0;
                    w_tag_ok_nxt = 1'b0;
                end
            end
            WAIT_TAG: begin
                if (tag_valid_i) w_state_nxt = RECV;
            end
            RECV: begin
                // Every word is folded into the accumulator; no early exit on mismatch
                if (w_hs) begin
                    w_diff_nxt = r_diff | (rx_word_i ^ w_tag_word);
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (w_last) w_state_nxt = RESULT;
                end
            end
            RESULT: begin
                w_tag_ok_nxt = (r_diff == '0);
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort_i) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = '0;
            w_diff_nxt   = '0;
            w_tag_ok_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_tag_ok <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_diff   <= w_diff_nxt;
            r_tag_ok <= w_tag_ok_nxt;
        end
    end

    assign rx_ready_o = (r_state == RECV);
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == RESULT) && !abort_i;
    assign tag_ok_o   = r_tag_ok;
endmodule

// File: tb/tb_ascon_tag_verify.sv
// Directed + randomized bench for ascon_tag_verify; verdict model is a whole-tag equality.
module tb_ascon_tag_verify;
    logic         clock_i = 1'b0;
    logic         reset_i;
    logic [127:0] tag_i;
    logic         tag_valid_i;
    logic         start_i;
    logic         abort_i;
    logic [31:0]  rx_word_i;
    logic         rx_valid_i;
    logic         rx_ready_o;
    logic         busy_o;
    logic         done_o;
    logic         tag_ok_o;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [127:0] KTAG = 128'h0123456789ABCDEF_FEDCBA9876543210;

    ascon_tag_verify #(.TAG_W(128), .WORD_W(32)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .tag_i       (tag_i),
        .tag_valid_i (tag_valid_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .rx_word_i   (rx_word_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tag_ok_o    (tag_ok_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ready"}, rx_ready_o, 1'b0);
        chk({tag, "_busy"},  busy_o,     1'b0);
        chk({tag, "_done"},  done_o,     1'b0);
    endtask

    // One verification. abort_hs >= 0 aborts together with that handshake index.
    // tv_delay > 0 holds tag_valid_i low for that many cycles after start.
    task automatic xact(input logic [127:0] tag, input logic [127:0] rxw,
                        input int gap_pct, input int abort_hs, input int tv_delay,
                        input bit check_cyc);
        int hs  = 0;
        int cyc = 0;
        bit exp_ok;
        exp_ok      = (rxw == tag);
        tag_i       = tag;
        tag_valid_i = (tv_delay == 0);
        start_i     = 1'b1;
        step();
        start_i = 1'b0;
        cyc     = 1;
        chk("start_busy",  busy_o,   1'b1);
        chk("start_tagok", tag_ok_o, 1'b0);
        if (tv_delay > 0) begin
            for (int i = 0; i < tv_delay; i++) begin
                chk("waittag_ready", rx_ready_o, 1'b0);
                chk("waittag_busy",  busy_o,     1'b1);
                step();
            end
            tag_valid_i = 1'b1;
            step();
            chk("tagvalid_ready", rx_ready_o, 1'b1);
        end
        while (hs < 4 && cyc < 300) begin
            rx_valid_i = ($urandom_range(99) >= gap_pct);
            rx_word_i  = rxw[127 - 32*hs -: 32];
            abort_i    = (abort_hs == hs) && rx_valid_i && rx_ready_o;
            if (rx_valid_i && rx_ready_o) hs++;
            step();
            cyc++;
            if (abort_i) begin
                abort_i    = 1'b0;
                rx_valid_i = 1'b0;
                chk_idle_zero("abort");
                chk("abort_tagok", tag_ok_o, 1'b0);
                step();
                chk("abort_nodone", done_o, 1'b0);
                return;
            end
        end
        rx_valid_i = 1'b1;
        rx_word_i  = $urandom;
        chk("hs_count", hs, 4);
        chk("done_pulse",   done_o,     1'b1);
        chk("result_ready", rx_ready_o, 1'b0);
        if (check_cyc) chk("latency", cyc, 6);
        step();
        rx_valid_i = 1'b0;
        chk("done_clear", done_o,   1'b0);
        chk("end_busy",   busy_o,   1'b0);
        chk("verdict",    tag_ok_o, exp_ok);
    endtask

    initial begin
        logic [127:0] t;
        logic [127:0] r;
        reset_i = 1'b1; tag_i = '0; tag_valid_i = 1'b0; start_i = 1'b0;
        abort_i = 1'b0; rx_word_i = '0; rx_valid_i = 1'b0;
        #12;
        chk_idle_zero("reset");
        chk("reset_tagok", tag_ok_o, 1'b0);
        reset_i = 1'b0;
        step();

        // Good tag, then sticky check while idle
        xact(KTAG, KTAG, 0, -1, 0, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("sticky_idle", tag_ok_o, 1'b1);

        // Reset mid-RECV after two words
        tag_i = KTAG; tag_valid_i = 1'b1; start_i = 1'b1;
        step(); start_i = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            rx_valid_i = 1'b1; rx_word_i = KTAG[127 - 32*k -: 32];
            step();
        end
        rx_valid_i = 1'b0;
        reset_i = 1'b1;
        step();
        chk_idle_zero("midreset");
        chk("midreset_tagok", tag_ok_o, 1'b0);
        reset_i = 1'b0;
        step();
        xact(KTAG, KTAG, 0, -1, 0, 1'b1);

        // Single-bit flip in first word and in last word: same timing, failed verdict
        xact(KTAG, KTAG ^ (128'h1 << 96), 0, -1, 0, 1'b1);
        xact(KTAG, KTAG ^ 128'h1,         0, -1, 0, 1'b1);

        // tag_valid_i late by 5 cycles
        xact(KTAG, KTAG, 0, -1, 5, 1'b0);

        // Gappy stream, matching tag; verdict held until next start
        xact(KTAG, KTAG, 50, -1, 0, 1'b0);
        step(); step();
        chk("sticky_gap", tag_ok_o, 1'b1);

        // Abort with the third handshake, then a full fresh verification
        xact(KTAG, KTAG, 0, 2, 0, 1'b0);
        xact(KTAG, KTAG, 0, -1, 0, 1'b1);

        // start ignored while busy; abort beats start in IDLE
        start_i = 1'b1; abort_i = 1'b1;
        step();
        start_i = 1'b0; abort_i = 1'b0;
        chk("abort_over_start", busy_o, 1'b0);
        chk("abort_idle_tagok", tag_ok_o, 1'b0);

        // Randomized verifications
        for (int n = 0; n < 24; n++) begin
            t = {$urandom, $urandom, $urandom, $urandom};
            r = t;
            if ($urandom_range(1)) r = t ^ (128'h1 << $urandom_range(127));
            xact(t, r, $urandom_range(60), -1, $urandom_range(1) * $urandom_range(3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
